sgdma_descriptor_fetch: RTL and testbench

Descriptor-chain walker that sits directly upstream of the 1024x32 single-port descriptor RAM in the Ethernet Qsys subsystem. It acts as that RAM's Avalon-MM master and follows a linked list of 4-word descriptors. Each valid descriptor is handed to the SGDMA data mover through a valid/ready handshake, and its completion status is written back into the descriptor. A chain is started by software (Nios II CSR) and runs until an unowned descriptor, a stop request, or an error.

---
 rtl/sgdma_descriptor_fetch.sv | 233 +++++++++++++++++++++++
 tb/tb_sgdma_descriptor_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdma_descriptor_fetch.sv
// Descriptor-chain walker: fetches 4-word descriptors, hands them to the data
// mover and writes status back. Optional chain-complete irq: SGDMA_DESC_FETCH_IRQ_EN.
module sgdma_descriptor_fetch #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_CHAIN = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_ptr,
  input  logic                stop,
  output logic                busy,
  output logic [2:0]          err,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [31:0]         d_src,
  output logic [31:0]         d_dst,
  output logic [15:0]         d_len,
  output logic                d_eop,
  input  logic                done,
  input  logic [15:0]         done_len,
  input  logic [7:0]          done_status,
  output logic                irq,
  input  logic                irq_clear
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(MAX_CHAIN + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_ADV     = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     chain_q, chain_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              wb_q, wb_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [15:0]       len_q, len_d;
  logic              eop_q, eop_d;
  logic              own_q, own_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [15:0]       dlen_q, dlen_d;
  logic [7:0]        dstat_q, dstat_d;
  logic [2:0]        err_q, err_d;
  logic              stop_q, stop_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    chain_d = chain_q;
    fcnt_d  = fcnt_q;
    wb_d    = wb_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    eop_d   = eop_q;
    own_d   = own_q;
    nxt_d   = nxt_q;
    dlen_d  = dlen_q;
    dstat_d = dstat_q;
    err_d   = err_q;
    stop_d  = stop_q | ((state_q != S_IDLE) & stop);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = start_ptr;
          err_d   = 3'd0;
          chain_d = '0;
          fcnt_d  = 3'd0;
          stop_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        fcnt_d = fcnt_q + 3'd1;
        // word k arrives the cycle after its read, i.e. at fcnt k+1
        case (fcnt_q)
          3'd1: src_d = m_readdata[31:0];
          3'd2: dst_d = m_readdata[31:0];
          3'd3: begin
            own_d = m_readdata[31];
            eop_d = m_readdata[30];
            len_d = m_readdata[15:0];
          end
          3'd4: begin
            nxt_d   = m_readdata[ADDR_W-1:0];
            fcnt_d  = 3'd0;
            state_d = S_CHECK;
          end
          default: ;
        endcase
      end
      S_CHECK: begin
        if (!own_q) begin
          state_d = S_IDLE;
        end else if (len_q == 16'd0) begin
          err_d   = 3'd1;
          state_d = S_IDLE;
        end else if (nxt_q[1:0] != 2'b00) begin
          err_d   = 3'd2;
          state_d = S_IDLE;
        end else if (chain_q == CW'(MAX_CHAIN)) begin
          err_d   = 3'd3;
          state_d = S_IDLE;
        end else if (stop_d) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (d_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          dlen_d  = done_len;
          dstat_d = done_status;
          wb_d    = 1'b0;
          state_d = S_WB;
        end
      end
      S_WB: begin
        wb_d = 1'b1;
        if (wb_q) state_d = S_ADV;
      end
      S_ADV: begin
        chain_d = chain_q + CW'(1);
        ptr_d   = nxt_q;
        fcnt_d  = 3'd0;
        state_d = stop_d ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      chain_q <= '0;
      fcnt_q  <= 3'd0;
      wb_q    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      eop_q   <= 1'b0;
      own_q   <= 1'b0;
      nxt_q   <= '0;
      dlen_q  <= '0;
      dstat_q <= '0;
      err_q   <= 3'd0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      chain_q <= chain_d;
      fcnt_q  <= fcnt_d;
      wb_q    <= wb_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      eop_q   <= eop_d;
      own_q   <= own_d;
      nxt_q   <= nxt_d;
      dlen_q  <= dlen_d;
      dstat_q <= dstat_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;
  assign m_read  = (state_q == S_FETCH) && !fcnt_q[2];
  assign m_write = (state_q == S_WB);

  always_comb begin
    m_address = '0;
    if (m_read)
      m_address = ptr_q + ADDR_W'(fcnt_q[1:0]);
    else if (m_write)
      m_address = ptr_q + ADDR_W'(2);
  end

  // first beat updates len/status under byte 3; second beat clears OWN alone
  assign m_byteenable = !m_write ? '0
                      : wb_q ? BE_W'(4'b1000)
                      : BE_W'(4'b0111);
  assign m_writedata = (m_write && !wb_q)
                     ? DATA_W'({8'h00, dstat_q, dlen_q})
                     : '0;

  assign d_valid = (state_q == S_PRESENT);
  assign d_src   = src_q;
  assign d_dst   = dst_q;
  assign d_len   = len_q;
  assign d_eop   = eop_q;

`ifdef SGDMA_DESC_FETCH_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (reset)
      irq_q <= 1'b0;
    else if (state_q != S_IDLE && state_d == S_IDLE)
      irq_q <= 1'b1;
    else if (irq_clear)
      irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = irq_clear;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sgdma_descriptor_fetch.sv
// Directed bench for sgdma_descriptor_fetch with a behavioural descriptor RAM
// and a scripted data mover; MAX_CHAIN is overridden to 4.
module tb_sgdma_descriptor_fetch;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_ptr = '0;
  logic          stop = 1'b0;
  logic          d_ready = 1'b0;
  logic          done = 1'b0;
  logic [15:0]   done_len = '0;
  logic [7:0]    done_status = '0;
  logic          irq_clear = 1'b0;
  logic [31:0]   m_readdata = '0;

  logic          busy, m_read, m_write, d_valid, d_eop, irq;
  logic [2:0]    err;
  logic [AW-1:0] m_address;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_writedata, d_src, d_dst;
  logic [15:0]   d_len;

  sgdma_descriptor_fetch #(
    .ADDR_W(AW), .DATA_W(32), .MAX_CHAIN(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .start_ptr(start_ptr), .stop(stop), .busy(busy),
    .err(err), .m_address(m_address), .m_read(m_read),
    .m_readdata(m_readdata), .m_write(m_write),
    .m_byteenable(m_byteenable),
    .m_writedata(m_writedata), .d_valid(d_valid),
    .d_ready(d_ready), .d_src(d_src), .d_dst(d_dst),
    .d_len(d_len), .d_eop(d_eop), .done(done),
    .done_len(done_len), .done_status(done_status),
    .irq(irq), .irq_clear(irq_clear)
  );

  // descriptor RAM; own_lock models software re-arming OWN
  logic [31:0]   mem [0:1023] = '{default: '0};
  logic          own_lock = 1'b0;
  logic          hw_en = 1'b0;
  logic [AW-1:0] hw_a = '0;
  logic [31:0]   hw_d = '0;

  always @(posedge clk) begin
    if (m_read) m_readdata <= mem[m_address];
    if (hw_en)
      mem[hw_a] <= hw_d;
    else if (m_write)
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b] && !(own_lock && b == 3))
          mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
  end

  int hs_n = 0, wr_n = 0, rd_n = 0, dv_n = 0, bad_n = 0;
  logic [AW-1:0] ra [0:255];
  logic [AW-1:0] wa [0:63];
  logic [3:0]    wbe [0:63];
  logic [31:0]   wdat [0:63];

  always @(negedge clk) begin
    if (!reset) begin
      if (d_valid) dv_n <= dv_n + 1;
      if (d_valid && d_ready) hs_n <= hs_n + 1;
      if (m_read && m_write) bad_n <= bad_n + 1;
      if (m_read) begin
        if (rd_n < 256) ra[rd_n] <= m_address;
        rd_n <= rd_n + 1;
      end
      if (m_write) begin
        if (wr_n < 64) begin
          wa[wr_n]   <= m_address;
          wbe[wr_n]  <= m_byteenable;
          wdat[wr_n] <= m_writedata;
        end
        wr_n <= wr_n + 1;
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hw(input logic [AW-1:0] a, input logic [31:0] d);
    hw_en = 1'b1;
    hw_a  = a;
    hw_d  = d;
    tick();
    hw_en = 1'b0;
  endtask

  task automatic put_desc(input logic [AW-1:0] b,
                          input logic [31:0] s, input logic [31:0] d,
                          input logic own, input logic eop,
                          input logic [15:0] len,
                          input logic [AW-1:0] nxt);
    hw(b, s);
    hw(b + AW'(1), d);
    hw(b + AW'(2), {own, eop, 6'h0, 8'h00, len});
    hw(b + AW'(3), 32'(nxt));
  endtask

  task automatic kick(input logic [AW-1:0] p);
    start_ptr = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic serve(input string tag, input int stall,
                       input logic [31:0] es, input logic [31:0] ed,
                       input logic [15:0] el, input logic ee,
                       input logic [15:0] dl, input logic [7:0] ds,
                       input bit do_stop);
    logic [31:0] s0, d0;
    logic [15:0] l0;
    bit stable;
    for (int i = 0; i < 60 && !d_valid; i++) tick();
    chk({tag, "_dvalid"}, 32'(d_valid), 32'd1);
    if (!d_valid) return;
    chk({tag, "_src"}, d_src, es);
    chk({tag, "_dst"}, d_dst, ed);
    chk({tag, "_len"}, 32'(d_len), 32'(el));
    chk({tag, "_eop"}, 32'(d_eop), 32'(ee));
    s0 = d_src;
    d0 = d_dst;
    l0 = d_len;
    stable = 1'b1;
    repeat (stall) begin
      tick();
      if (d_valid !== 1'b1 || d_src !== s0 ||
          d_dst !== d0 || d_len !== l0)
        stable = 1'b0;
    end
    if (stall > 0) chk({tag, "_stable"}, 32'(stable), 32'd1);
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    if (do_stop) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    tick();
    tick();
    done = 1'b1;
    done_len = dl;
    done_status = ds;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80 && busy; i++) tick();
    chk(tag, 32'(busy), 32'd0);
  endtask

  int h0, w0, r0, v0;

  task automatic snap();
    h0 = hs_n;
    w0 = wr_n;
    r0 = rd_n;
    v0 = dv_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ctl", 32'({busy, m_read, m_write, d_valid, irq, err}), 32'd0);
    chk("rst_bus", 32'(m_address) | m_writedata | 32'(m_byteenable), 32'd0);
    chk("rst_d", d_src | d_dst | 32'(d_len) | 32'(d_eop), 32'd0);
    reset = 1'b0;
    tick();

    // single descriptor, then an unowned one
    put_desc(10'h000, 32'h1000, 32'h2000, 1'b1, 1'b1, 16'd64, 10'h004);
    put_desc(10'h004, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, 10'h008);
    snap();
    kick(10'h000);
    serve("t1", 0, 32'h1000, 32'h2000, 16'd64, 1'b1, 16'd64, 8'h00, 1'b0);
    wait_idle("t1_idle");
    chk("t1_hs", 32'(hs_n - h0), 32'd1);
    chk("t1_wr", 32'(wr_n - w0), 32'd2);
    chk("t1_rd", 32'(rd_n - r0), 32'd8);
    chk("t1_ra0", 32'(ra[r0]), 32'h000);
    chk("t1_ra3", 32'(ra[r0+3]), 32'h003);
    chk("t1_ra4", 32'(ra[r0+4]), 32'h004);
    chk("t1_ra7", 32'(ra[r0+7]), 32'h007);
    chk("t1_wa0", 32'(wa[w0]), 32'h002);
    chk("t1_wbe0", 32'(wbe[w0]), 32'h7);
    chk("t1_wd0", wdat[w0], 32'h0000_0040);
    chk("t1_wa1", 32'(wa[w0+1]), 32'h002);
    chk("t1_wbe1", 32'(wbe[w0+1]), 32'h8);
    chk("t1_wd1", wdat[w0+1], 32'h0);
    chk("t1_mem", mem[2], 32'h0000_0040);
    chk("t1_err", 32'(err), 32'd0);
`ifdef SGDMA_DESC_FETCH_IRQ_EN
    chk("t1_irq", 32'(irq), 32'd1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    chk("t1_irqclr", 32'(irq), 32'd0);
`else
    chk("t1_irq", 32'(irq), 32'd0);
`endif

    // three-descriptor chain wrapping past 0x3FF, stall on the second
    put_desc(10'h010, 32'h100, 32'h200, 1'b1, 1'b0, 16'd100, 10'h020);
    put_desc(10'h020, 32'h300, 32'h400, 1'b1, 1'b1, 16'd200, 10'h3FC);
    put_desc(10'h3FC, 32'h500, 32'h600, 1'b1, 1'b0, 16'd300, 10'h000);
    put_desc(10'h000, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, 10'h004);
    snap();
    kick(10'h010);
    serve("t2a", 0, 32'h100, 32'h200, 16'd100, 1'b0, 16'd100, 8'h11, 1'b0);
    serve("t2b", 10, 32'h300, 32'h400, 16'd200, 1'b1, 16'd150, 8'h22, 1'b0);
    serve("t2c", 0, 32'h500, 32'h600, 16'd300, 1'b0, 16'd300, 8'h33, 1'b0);
    wait_idle("t2_idle");
    chk("t2_hs", 32'(hs_n - h0), 32'd3);
    chk("t2_wr", 32'(wr_n - w0), 32'd6);
    chk("t2_rd", 32'(rd_n - r0), 32'd16);
    chk("t2_ra8", 32'(ra[r0+8]), 32'h3FC);
    chk("t2_ra11", 32'(ra[r0+11]), 32'h3FF);
    chk("t2_ra12", 32'(ra[r0+12]), 32'h000);
    chk("t2_ra15", 32'(ra[r0+15]), 32'h003);
    chk("t2_wa5", 32'(wa[w0+5]), 32'h3FE);
    chk("t2_mem12", mem[10'h012], 32'h0011_0064);
    chk("t2_mem22", mem[10'h022], 32'h0022_0096);
    chk("t2_mem3fe", mem[10'h3FE], 32'h0033_012C);
    chk("t2_err", 32'(err), 32'd0);

    // zero length
    put_desc(10'h040, 32'h1, 32'h2, 1'b1, 1'b0, 16'd0, 10'h044);
    snap();
    kick(10'h040);
    wait_idle("t3_idle");
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_dv", 32'(dv_n - v0), 32'd0);
    chk("t3_wr", 32'(wr_n - w0), 32'd0);

    // misaligned next pointer
    put_desc(10'h080, 32'h1, 32'h2, 1'b1, 1'b0, 16'd8, 10'h013);
    snap();
    kick(10'h080);
    wait_idle("t4_idle");
    chk("t4_err", 32'(err), 32'd2);
    chk("t4_dv", 32'(dv_n - v0), 32'd0);
    chk("t4_wr", 32'(wr_n - w0), 32'd0);

    // self-loop hits the chain limit of 4
    put_desc(10'h100, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0, 16'd32, 10'h100);
    own_lock = 1'b1;
    snap();
    kick(10'h100);
    for (int k = 0; k < 4; k++)
      serve("t5", 0, 32'hAAAA, 32'hBBBB, 16'd32, 1'b0, 16'd32, 8'h44, 1'b0);
    wait_idle("t5_idle");
    own_lock = 1'b0;
    chk("t5_err", 32'(err), 32'd3);
    chk("t5_hs", 32'(hs_n - h0), 32'd4);
    chk("t5_wr", 32'(wr_n - w0), 32'd8);
    chk("t5_rd", 32'(rd_n - r0), 32'd20);

    // stop during WAIT_DONE of the first of two
    put_desc(10'h200, 32'h7, 32'h8, 1'b1, 1'b0, 16'd16, 10'h204);
    put_desc(10'h204, 32'h9, 32'hA, 1'b1, 1'b0, 16'd16, 10'h208);
    put_desc(10'h208, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, 10'h20C);
    snap();
    kick(10'h200);
    serve("t6", 0, 32'h7, 32'h8, 16'd16, 1'b0, 16'd16, 8'h00, 1'b1);
    wait_idle("t6_idle");
    chk("t6_hs", 32'(hs_n - h0), 32'd1);
    chk("t6_wr", 32'(wr_n - w0), 32'd2);
    chk("t6_rd", 32'(rd_n - r0), 32'd4);
    chk("t6_err", 32'(err), 32'd0);

    // reset while presenting
    put_desc(10'h300, 32'hC0DE, 32'hF00D, 1'b1, 1'b1, 16'd48, 10'h304);
    put_desc(10'h304, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, 10'h308);
    snap();
    kick(10'h300);
    for (int i = 0; i < 60 && !d_valid; i++) tick();
    chk("t7_dvalid", 32'(d_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("t7_ctl", 32'({busy, m_read, m_write, d_valid, irq, err}), 32'd0);
    chk("t7_bus", d_src | d_dst | 32'(d_len) | 32'(m_address), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("t7_wr", 32'(wr_n - w0), 32'd0);
    chk("t7_own", 32'(mem[10'h302][31]), 32'd1);

    // start and stop together in IDLE: start wins
    snap();
    start_ptr = 10'h300;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    serve("t8", 0, 32'hC0DE, 32'hF00D, 16'd48, 1'b1, 16'd48, 8'h55, 1'b0);
    wait_idle("t8_idle");
    chk("t8_hs", 32'(hs_n - h0), 32'd1);
    chk("t8_mem", mem[10'h302], 32'h0055_0030);

    chk("rw_overlap", 32'(bad_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
